// File: rtl/array_element_streamer.sv
// Streams the columns of a captured packed vector one element per handshake,
// forward or reversed, with an optional shortened frame length.
//
// state    | meaning
// S_IDLE   | no frame held; in_ready follows rst_n/abort
// S_STREAM | presenting element pos_q of the captured frame
module array_element_streamer #(
    parameter  int BIT_WIDTH = 4,
    parameter  int COLS      = 8,
    localparam int IDX_W     = $clog2(COLS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [COLS*BIT_WIDTH-1:0] in_data,
    input  logic [IDX_W:0]            in_len,
    input  logic                      in_reverse,
    input  logic                      abort,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BIT_WIDTH-1:0]      out_data,
    output logic [IDX_W-1:0]          out_index,
    output logic                      out_last,
    output logic                      busy,
    output logic [15:0]               frame_count
);

    localparam logic [0:0]     S_IDLE   = 1'b0;
    localparam logic [0:0]     S_STREAM = 1'b1;
    localparam logic [IDX_W:0] COLS_L   = (IDX_W+1)'(COLS);
    localparam logic [IDX_W:0] ONE      = (IDX_W+1)'(1);

    logic [0:0]                     state_q, state_d;
    logic [COLS-1:0][BIT_WIDTH-1:0] data_q, data_d;
    logic [IDX_W:0]                 len_q, len_d;
    logic [IDX_W:0]                 pos_q, pos_d;
    logic                           rev_q, rev_d;
    logic [15:0]                    frame_count_q, frame_count_d;

    logic           streaming;
    logic           last_elem;
    logic           elem_hs;
    logic           accept;
    logic [IDX_W:0] last_pos;
    logic [IDX_W:0] col;
    logic [IDX_W:0] eff_len;

    assign streaming = (state_q == S_STREAM);
    assign last_pos  = len_q - ONE;
    // pos_q counts elements already sent; col maps that onto a column number
    assign col       = rev_q ? (last_pos - pos_q) : pos_q;
    assign last_elem = streaming & (pos_q == last_pos);
    assign elem_hs   = streaming & out_ready;
    assign in_ready  = rst_n & ~abort & (~streaming | (elem_hs & last_elem));
    assign accept    = in_valid & in_ready;
    assign eff_len   = (in_len == '0 || in_len > COLS_L) ? COLS_L : in_len;

    assign out_valid   = streaming;
    assign busy        = streaming;
    assign out_last    = last_elem;
    assign out_index   = streaming ? col[IDX_W-1:0] : '0;
    assign out_data    = streaming ? data_q[col[IDX_W-1:0]] : '0;
    assign frame_count = frame_count_q;

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        len_d         = len_q;
        pos_d         = pos_q;
        rev_d         = rev_q;
        frame_count_d = frame_count_q;
        if (streaming && abort) begin
            state_d = S_IDLE;
        end else begin
            if (elem_hs) begin
                if (last_elem) begin
                    state_d       = S_IDLE;
                    frame_count_d = frame_count_q + 16'd1;
                end else begin
                    pos_d = pos_q + ONE;
                end
            end
            // acceptance on the last handshake overrides the return to idle
            if (accept) begin
                state_d = S_STREAM;
                data_d  = in_data;
                len_d   = eff_len;
                rev_d   = in_reverse;
                pos_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            data_q        <= '0;
            len_q         <= '0;
            pos_q         <= '0;
            rev_q         <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            len_q         <= len_d;
            pos_q         <= pos_d;
            rev_q         <= rev_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_array_element_streamer.sv
// Bench for array_element_streamer: directed scenarios plus random traffic,
// all checked against a queue-of-expected-elements reference model.
module tb_array_element_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_len;
    logic        in_reverse;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_data;
    logic [2:0]  out_index;
    logic        out_last;
    logic        busy;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    array_element_streamer #(.BIT_WIDTH(4), .COLS(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_len(in_len), .in_reverse(in_reverse), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] d;
        logic [2:0] i;
        logic       l;
    } elem_t;

    elem_t exp_q[$];
    int    exp_fc = 0;

    function automatic logic exp_ir();
        if (!rst_n || abort) return 1'b0;
        if (exp_q.size() == 0) return 1'b1;
        return out_ready && exp_q[0].l;
    endfunction

    function automatic logic [26:0] exp_vec();
        elem_t e;
        logic  v;
        v = (exp_q.size() > 0);
        e = '{d: 4'h0, i: 3'h0, l: 1'b0};
        if (v) e = exp_q[0];
        return {v, e.d, e.i, e.l, exp_ir(), v, 16'(exp_fc)};
    endfunction

    function automatic logic [26:0] act_vec();
        return {out_valid, out_data, out_index, out_last, in_ready, busy, frame_count};
    endfunction

    task automatic push_frame();
        int    len;
        int    c;
        elem_t e;
        len = (in_len == 0 || in_len > 8) ? 8 : int'(in_len);
        for (int k = 0; k < len; k++) begin
            c   = in_reverse ? (len - 1 - k) : k;
            e.d = in_data[c*4 +: 4];
            e.i = 3'(c);
            e.l = (k == len - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic model_step();
        logic ir;
        ir = exp_ir();
        if (!rst_n) begin
            exp_q.delete();
            exp_fc = 0;
        end else if (exp_q.size() > 0 && abort) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0 && out_ready) begin
                if (exp_q[0].l) exp_fc = (exp_fc + 1) % 65536;
                void'(exp_q.pop_front());
            end
            if (in_valid && ir) push_frame();
        end
    endtask

    task automatic adv();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_data    = 32'h7654_3210;
        in_len     = 4'd0;
        in_reverse = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            adv();
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_in_ready: got %b expected 1", in_ready);
        end
        adv();
    endtask

    task automatic test_forward();
        int seen = 0;
        idle_inputs();
        for (int c = 0; c < 11; c++) begin
            in_valid = (c == 0);
            @(negedge clk);
            if (out_valid) seen++;
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL forward cyc %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            adv();
        end
        n_checks++;
        if (seen !== 8 || frame_count !== 16'd1) begin
            n_fail++;
            $display("FAIL forward_totals: got elems %0d count %0d expected 8 and 1", seen, frame_count);
        end
    endtask

    task automatic test_reverse();
        idle_inputs();
        for (int c = 0; c < 6; c++) begin
            in_valid   = (c == 0);
            in_len     = 4'd3;
            in_reverse = 1'b1;
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reverse cyc %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            adv();
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reverse_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_stall();
        idle_inputs();
        for (int c = 0; c < 14; c++) begin
            in_valid  = (c == 0);
            out_ready = !(c >= 5 && c <= 7);
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stall cyc %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            adv();
        end
    endtask

    task automatic test_back_to_back();
        int nv = 0;
        idle_inputs();
        for (int c = 0; c < 20; c++) begin
            in_valid = (c <= 8);
            in_data  = (c == 0) ? 32'h7654_3210 : 32'hFEDC_BA98;
            @(negedge clk);
            if (out_valid) nv++;
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL back_to_back cyc %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            adv();
        end
        n_checks++;
        if (nv !== 16) begin
            n_fail++;
            $display("FAIL back_to_back_valid_cycles: got %0d expected 16", nv);
        end
    endtask

    task automatic test_abort();
        idle_inputs();
        for (int c = 0; c < 7; c++) begin
            in_valid = (c == 0);
            abort    = (c == 3);
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL abort cyc %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            adv();
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        for (int c = 0; c < 18; c++) begin
            rst_n    = (c != 6);
            in_valid = (c == 0 || c == 7);
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_mid cyc %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            adv();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            in_valid   = $urandom_range(0, 1);
            in_data    = $urandom;
            in_len     = 4'($urandom_range(0, 15));
            in_reverse = $urandom_range(0, 1);
            abort      = ($urandom_range(0, 24) == 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            adv();
        end
        rst_n = 1'b1;
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_forward();
        test_reverse();
        test_stall();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
